eq_nband_tdm: RTL and testbench
===============================

Name: eq_nband_tdm

Overview:
- Parametrised N-band graphic equaliser: each band is a TAPS-tap FIR over a shared input delay line, scaled by a per-band gain; the weighted bands are summed and saturated to one output sample.
- A single time-multiplexed MAC replaces one filter instance per band. Band coefficients and gains are runtime-loadable.
- Sits between the audio sample source and the output stage. Runs one sample at a time under a valid/ready handshake.

Parameters:
- N_BANDS, 8, number of bands (>=1)
- TAPS, 16, taps per band FIR (>=2)
- DATA_W, 16, signed input sample width
- COEF_W, 16, signed coefficient width; format Q1.COEF_FRAC
- COEF_FRAC, 15, coefficient fractional bits
- GAIN_W, 8, signed gain width; format Q.GAIN_FRAC
- GAIN_FRAC, 6, gain fractional bits (64 = unity)
- OUT_W, 32, signed output width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; when low, all state and the FSM freeze and in_ready is 0
- x_in  in  DATA_W  signed input sample
- in_valid  in  1  x_in valid
- in_ready  out  1  block can accept a sample
- y_out  out  OUT_W  signed equalised sample; holds its value until the next result
- out_valid  out  1  one-cycle pulse, y_out updated
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  1  0 = coefficient, 1 = gain
- cfg_band  in  clog2(N_BANDS)  band index
- cfg_tap  in  clog2(TAPS)  tap index; ignored for gain writes
- cfg_data  in  max(COEF_W,GAIN_W)  value, LSB-aligned
- cfg_ready  out  1  write accepted this cycle

Behaviour:
- Reset: y_out=0, out_valid=0, in_ready=0 during reset. Delay line, accumulators and total are 0. All coefficients are 0. All gains are 1<<GAIN_FRAC (unity). FSM enters IDLE.
- in_ready = ena && state==IDLE. A sample is accepted on a clk edge where in_valid && in_ready.
- On accept: the delay line shifts (d[0]=x_in, d[k]=d[k-1]); FSM goes to MAC with band=0, tap=0.
- MAC state, one tap per cycle: acc += d[tap]*coef[band][tap]. acc is full precision (DATA_W+COEF_W+clog2(TAPS) bits). Transition after tap==TAPS-1.
- GAIN state, one cycle:
  - w = ((acc>>>COEF_FRAC) * gain[band]) >>> GAIN_FRAC (arithmetic shifts, floor).
  - total += w; acc is cleared.
  - If band==N_BANDS-1, go to DONE; otherwise band+1, tap=0, back to MAC.
- Width of total: guard bits (+clog2(N_BANDS)+GAIN_W) so no internal overflow occurs.
- DONE state, one cycle:
  - y_out = sat(total) clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_valid=1 on the next cycle.
  - total is cleared; FSM returns to IDLE.
- Latency: out_valid rises exactly N_BANDS*(TAPS+1)+1 cycles after the accept edge (137 for defaults, ena held high). in_ready is high in the same cycle as out_valid.
- Throughput: one sample per N_BANDS*(TAPS+1)+1 cycles; in_valid asserted while busy is held off, not dropped.
- Config writes:
  - cfg_ready = (state==IDLE) && ena. A write occurs when cfg_we && cfg_ready.
  - Writes while busy are not taken; the master holds cfg_we until cfg_ready.
  - A simultaneous sample accept and cfg write both take effect; the new coefficient/gain applies to that sample.
  - An out-of-range cfg_band/cfg_tap is ignored, with cfg_ready still asserted.
- ena low mid-computation: pause with no state change; resume on return to high. The latency counts only ena-high cycles.
- rst_n asserted mid-computation: immediate abort to reset values; no out_valid is produced for the in-flight sample.

Optional Feature:
- Macro EQ_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled at accept. When it was 1, DONE loads y_out = sign-extended x_in (saturated to OUT_W) instead of sat(total). Latency and handshake are unchanged; the delay line still shifts.
- Undefined: no bypass port; the output is always the filtered sum.

Decomposition:
- Package eq_pkg:
  - FSM state enum (IDLE, MAC, GAIN, DONE)
  - the cfg_sel encodings
  - a saturate function
  - the unity-gain constant
  - a width-helper function for acc/total
- One sub-module: eq_mac_unit, containing the signed multiplier, the accumulator, and the gain scale/accumulate datapath. The top holds the FSM, delay line, coefficient/gain register files and handshakes.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> y_out=0, out_valid=0, in_ready=0; after release, in_ready=1 next cycle with ena=1, and gains read back as unity via an impulse test.
- Impulse, defaults:
  - Setup: band0 coef[k]=k*1024, all other bands' coefs 0, gains unity.
  - Stimulus: x=32767 then 15 zeros.
  - Required y sequence: 0, 1023, 2047, ..., 15359. Each out_valid is exactly 137 cycles after its accept.
- Gain: same impulse with band0 gain=0 -> all outputs 0; gain=32 (0.5) -> 0, 511, 1023, ...
- Saturation, OUT_W=20:
  - Setup: all coefs 32767, all gains 127.
  - Steady x=32767 -> y=524287; steady x=-32768 -> y=-524288.
- Handshake:
  - in_valid held high continuously -> one accept per 137 cycles, with no sample lost or duplicated (checked against the scoreboard).
  - cfg_we raised while busy -> cfg_ready=0 until IDLE, then the write lands.
  - ena dropped for 10 cycles mid-MAC -> out_valid is delayed by exactly 10 cycles with the same value.
- EQ_BYPASS_EN: bypass=1 with x=-5 -> y_out=-5 after 137 cycles; the next sample with bypass=0 -> the filtered result includes -5 in the delay line.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types, constants and helpers for the time-multiplexed N-band equaliser.
// The top accepts an optional bypass path when EQ_BYPASS_EN is defined.
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_GAIN = 2'd2,
    ST_DONE = 2'd3
  } eq_state_e;

  localparam logic CFG_SEL_COEF = 1'b0;
  localparam logic CFG_SEL_GAIN = 1'b1;

  // Wide enough to carry any accumulator total into the saturator.
  localparam int SAT_W = 128;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + idx_w(taps);
  endfunction

  function automatic int tot_w(input int data_w, input int coef_w, input int taps,
                               input int gain_w, input int n_bands);
    return acc_w(data_w, coef_w, taps) + gain_w + idx_w(n_bands);
  endfunction

  function automatic int unity_gain(input int gain_frac);
    return 1 << gain_frac;
  endfunction

  // Clamp a sign-extended value to the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int out_w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    min_v = ~max_v;
    if (v > max_v)      return max_v;
    else if (v < min_v) return min_v;
    else                return v;
  endfunction

endpackage

// File: rtl/eq_mac_unit.sv
// Shared MAC for all bands: tap accumulate, then per-band gain scale into the running total.
module eq_mac_unit
  import eq_pkg::*;
#(
  parameter int N_BANDS   = 8,
  parameter int TAPS      = 16,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   i_mac,
  input  logic                                                   i_gain,
  input  logic                                                   i_clr,
  input  logic signed [DATA_W-1:0]                               i_x,
  input  logic signed [COEF_W-1:0]                               i_coef,
  input  logic signed [GAIN_W-1:0]                               i_gain_val,
  output logic signed [tot_w(DATA_W, COEF_W, TAPS, GAIN_W, N_BANDS)-1:0] o_total
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int SCL_W  = ACC_W + GAIN_W;
  localparam int TOT_W  = tot_w(DATA_W, COEF_W, TAPS, GAIN_W, N_BANDS);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_q;
  logic signed [SCL_W-1:0]  w_scaled;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [TOT_W-1:0]  r_total;

  assign w_prod   = PROD_W'(i_x) * PROD_W'(i_coef);
  // Floor back to integer sample units, then apply the band gain with a floor shift.
  assign w_acc_q  = r_acc >>> COEF_FRAC;
  assign w_scaled = (SCL_W'(w_acc_q) * SCL_W'(i_gain_val)) >>> GAIN_FRAC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_total <= '0;
    end else if (i_mac) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end else if (i_gain) begin
      r_acc   <= '0;
      r_total <= r_total + TOT_W'(w_scaled);
    end else if (i_clr) begin
      r_total <= '0;
    end
  end

  assign o_total = r_total;

endmodule

// File: rtl/eq_nband_tdm.sv
// N-band graphic equaliser on one time-multiplexed MAC; FSM, delay line and config files.
// Optional EQ_BYPASS_EN adds a per-sample bypass input that forwards the sample itself.
module eq_nband_tdm
  import eq_pkg::*;
#(
  parameter int N_BANDS   = 8,
  parameter int TAPS      = 16,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int OUT_W     = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic signed [DATA_W-1:0]           x_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [OUT_W-1:0]            y_out,
  output logic                               out_valid,
  input  logic                               cfg_we,
  input  logic                               cfg_sel,
  input  logic [idx_w(N_BANDS)-1:0]          cfg_band,
  input  logic [idx_w(TAPS)-1:0]             cfg_tap,
`ifdef EQ_BYPASS_EN
  input  logic                               bypass,
`endif
  input  logic [max_w(COEF_W, GAIN_W)-1:0]   cfg_data,
  output logic                               cfg_ready
);

  localparam int BAND_W = idx_w(N_BANDS);
  localparam int TAP_W  = idx_w(TAPS);
  localparam int TOT_W  = tot_w(DATA_W, COEF_W, TAPS, GAIN_W, N_BANDS);
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(N_BANDS - 1);

  eq_state_e                  r_state;
  eq_state_e                  w_state_nxt;
  logic [BAND_W-1:0]          r_band;
  logic [TAP_W-1:0]           r_tap;
  logic signed [DATA_W-1:0]   r_dly  [TAPS];
  logic signed [COEF_W-1:0]   r_coef [N_BANDS][TAPS];
  logic signed [GAIN_W-1:0]   r_gain [N_BANDS];
  logic signed [OUT_W-1:0]    r_y;
  logic                       r_out_valid;
  logic                       w_idle;
  logic                       w_accept;
  logic                       w_mac;
  logic                       w_gain;
  logic                       w_done;
  logic                       w_cfg_wr;
  logic                       w_band_ok;
  logic                       w_tap_ok;
  logic signed [TOT_W-1:0]    w_total;
  logic signed [OUT_W-1:0]    w_y_filt;
  logic signed [OUT_W-1:0]    w_y_next;

  assign w_idle    = rst_n && ena && (r_state == ST_IDLE);
  assign in_ready  = w_idle;
  assign cfg_ready = w_idle;
  assign w_cfg_wr  = cfg_we && w_idle;
  assign w_band_ok = int'(cfg_band) < N_BANDS;
  assign w_tap_ok  = int'(cfg_tap) < TAPS;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mac       = 1'b0;
    w_gain      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        w_mac = 1'b1;
        if (r_tap == TAP_LAST) w_state_nxt = ST_GAIN;
      end
      ST_GAIN: begin
        w_gain      = 1'b1;
        w_state_nxt = (r_band == BAND_LAST) ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_band      <= '0;
      r_tap       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) r_dly[k] <= '0;
    end else begin
      r_out_valid <= ena && w_done;
      if (ena) begin
        r_state <= w_state_nxt;
        if (w_accept) begin
          r_dly[0] <= x_in;
          for (int k = 1; k < TAPS; k++) r_dly[k] <= r_dly[k-1];
          r_band <= '0;
          r_tap  <= '0;
        end
        if (w_mac) r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + TAP_W'(1);
        if (w_gain && (r_band != BAND_LAST)) r_band <= r_band + BAND_W'(1);
        if (w_done) r_y <= w_y_next;
      end
    end
  end

  // Writes share the accept edge, so a new coefficient already applies to that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANDS; b++) begin
        r_gain[b] <= GAIN_W'(unity_gain(GAIN_FRAC));
        for (int t = 0; t < TAPS; t++) r_coef[b][t] <= '0;
      end
    end else if (w_cfg_wr && w_band_ok) begin
      if (cfg_sel == CFG_SEL_COEF) begin
        if (w_tap_ok) r_coef[cfg_band][cfg_tap] <= cfg_data[COEF_W-1:0];
      end else begin
        r_gain[cfg_band] <= cfg_data[GAIN_W-1:0];
      end
    end
  end

  eq_mac_unit #(
    .N_BANDS   (N_BANDS),
    .TAPS      (TAPS),
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mac      (ena && w_mac),
    .i_gain     (ena && w_gain),
    .i_clr      (ena && w_done),
    .i_x        (r_dly[r_tap]),
    .i_coef     (r_coef[r_band][r_tap]),
    .i_gain_val (r_gain[r_band]),
    .o_total    (w_total)
  );

  assign w_y_filt = OUT_W'(saturate(SAT_W'(w_total), OUT_W));

`ifdef EQ_BYPASS_EN
  logic                     r_byp;
  logic signed [DATA_W-1:0] r_x_byp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp   <= 1'b0;
      r_x_byp <= '0;
    end else if (ena && w_accept) begin
      r_byp   <= bypass;
      r_x_byp <= x_in;
    end
  end

  assign w_y_next = r_byp ? OUT_W'(saturate(SAT_W'(r_x_byp), OUT_W)) : w_y_filt;
`else
  assign w_y_next = w_y_filt;
`endif

  assign y_out     = r_y;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_eq_nband_tdm.sv
// Directed bench for eq_nband_tdm (8 bands x 16 taps, OUT_W=20 so saturation is reachable).
module tb_eq_nband_tdm;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic signed [15:0] x_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] y_out;
  logic               out_valid;
  logic               cfg_we;
  logic               cfg_sel;
  logic [2:0]         cfg_band;
  logic [3:0]         cfg_tap;
  logic [15:0]        cfg_data;
  logic               cfg_ready;
`ifdef EQ_BYPASS_EN
  logic               bypass = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eq_nband_tdm #(
    .N_BANDS(8), .TAPS(16), .DATA_W(16), .COEF_W(16), .COEF_FRAC(15),
    .GAIN_W(8), .GAIN_FRAC(6), .OUT_W(20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .out_valid (out_valid),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_band  (cfg_band),
    .cfg_tap   (cfg_tap),
`ifdef EQ_BYPASS_EN
    .bypass    (bypass),
`endif
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    ena      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic sel, input int band, input int tap, input int data);
    int n;
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_band = 3'(band);
    cfg_tap  = 4'(tap);
    cfg_data = 16'(data);
    n = 0;
    while (!cfg_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk("cfg_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) cfg_write(1'b0, 0, k, k * 1024);
  endtask

  // Send one sample, optionally freeze ena for 10 cycles starting pause_at cycles after accept.
  task automatic send(input int x, input bit keep, input int pause_at,
                      output int y, output int lat);
    int t0, n;
    x_in     = 16'(x);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    t0 = cyc;
    if (!keep) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 1000) begin
      if (n == pause_at) ena = 1'b0;
      if (pause_at >= 0 && n == pause_at + 10) ena = 1'b1;
      @(posedge clk); #1; n++;
    end
    y   = int'(y_out);
    lat = out_valid ? (cyc - t0) : -1;
  endtask

  function automatic int ramp_exp(input int n, input int div);
    return (n == 0) ? 0 : (n * 1024 / div - 1);
  endfunction

  initial begin
    int y, lat, n, seen;
    rst_n = 1'b0; ena = 1'b1; x_in = '0; in_valid = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_band = '0; cfg_tap = '0; cfg_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_cfgrdy", cfg_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", in_ready, 1);

    // Impulse through band 0 ramp, unity gains
    load_ramp();
    for (int k = 0; k < 16; k++) begin
      send((k == 0) ? 32767 : 0, 1'b0, -1, y, lat);
      chk($sformatf("imp_y%0d", k), y, ramp_exp(k, 1));
      chk($sformatf("imp_lat%0d", k), lat, 137);
      if (k == 0) begin
        @(posedge clk); #1;
        chk("ov_pulse", out_valid, 0);
        chk("y_hold", y_out, 0);
      end
    end

    // Band 0 gain = 0
    do_reset();
    load_ramp();
    cfg_write(1'b1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      send((k == 0) ? 32767 : 0, 1'b0, -1, y, lat);
      chk($sformatf("g0_y%0d", k), y, 0);
    end

    // Gain 0.5 written while busy: held off until IDLE, then applies to later samples
    do_reset();
    load_ramp();
    fork
      send(32767, 1'b0, -1, y, lat);
      begin
        repeat (5) begin @(posedge clk); #1; end
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_band = 3'd0; cfg_tap = 4'd0; cfg_data = 16'd32;
        chk("cfg_busy_rdy", cfg_ready, 0);
        n = 0;
        while (!cfg_ready && n < 1000) begin @(posedge clk); #1; n++; end
        chk("cfg_held_off", (n >= 120 && n < 1000) ? 1 : 0, 1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
      end
    join
    chk("g32_y0", y, 0);
    for (int k = 1; k < 4; k++) begin
      send(0, 1'b0, -1, y, lat);
      chk($sformatf("g32_y%0d", k), y, ramp_exp(k, 2));
    end

    // Reset mid-computation aborts; gains return to unity
    x_in = 16'sd32767; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_y", y_out, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_rdy", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rdy_after", in_ready, 1);
    seen = 0;
    repeat (200) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("abort_no_ov", seen, 0);
    load_ramp();
    send(32767, 1'b0, -1, y, lat);
    send(0, 1'b0, -1, y, lat);
    chk("unity_after_rst", y, 1023);

    // ena dropped for 10 cycles mid-MAC
    do_reset();
    load_ramp();
    send(32767, 1'b0, 20, y, lat);
    chk("ena_y0", y, 0);
    chk("ena_lat0", lat, 147);
    send(0, 1'b0, 40, y, lat);
    chk("ena_y1", y, 1023);
    chk("ena_lat1", lat, 147);

    // in_valid held high continuously: every sample accepted exactly once, in order
    do_reset();
    load_ramp();
    for (int k = 0; k < 6; k++) begin
      send((k == 0) ? 32767 : 0, (k < 5) ? 1'b1 : 1'b0, -1, y, lat);
      chk($sformatf("cont_y%0d", k), y, ramp_exp(k, 1));
      chk($sformatf("cont_lat%0d", k), lat, 137);
    end

`ifdef EQ_BYPASS_EN
    // Bypass forwards the sample; the delay line still captures it
    do_reset();
    load_ramp();
    bypass = 1'b1;
    send(-5, 1'b0, -1, y, lat);
    chk("byp_y", y, -5);
    chk("byp_lat", lat, 137);
    bypass = 1'b0;
    send(0, 1'b0, -1, y, lat);
    chk("byp_next_y", y, -1);
`endif

    // Saturation at OUT_W=20
    do_reset();
    for (int b = 0; b < 8; b++) begin
      for (int t = 0; t < 16; t++) cfg_write(1'b0, b, t, 32767);
      cfg_write(1'b1, b, 0, 127);
    end
    for (int k = 0; k < 16; k++) begin
      send(32767, 1'b0, -1, y, lat);
      if (k == 1)  chk("sat_pos1", y, 524287);
      if (k == 15) chk("sat_pos15", y, 524287);
    end
    for (int k = 0; k < 16; k++) begin
      send(-32768, 1'b0, -1, y, lat);
      if (k == 15) chk("sat_neg15", y, -524288);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
